// File: rtl/bft_pkg.sv
// bft_pkg: shared BFT constants, sender state encoding and packet field offsets
package bft_pkg;
  localparam int BFT_PACKET_BITS = 49;
  localparam int BFT_PAYLOAD_BITS = 32;
  localparam int BFT_NUM_LEAF_BITS = 3;
  localparam int BFT_NUM_PORT_BITS = 4;
  localparam int BFT_NUM_ADDR_BITS = 7;
  localparam int BFT_NUM_BRAM_ADDR_BITS = 7;
  localparam int BFT_FREESPACE_UPDATE_SIZE = 64;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} sender_state_t;
  function automatic int leaf_lsb(int packet_bits, int leaf_bits);
    return packet_bits - 1 - leaf_bits;
  endfunction
  function automatic int port_lsb(int packet_bits, int leaf_bits, int port_bits);
    return leaf_lsb(packet_bits, leaf_bits) - port_bits;
  endfunction
  function automatic int addr_lsb(int packet_bits, int leaf_bits, int port_bits, int addr_bits);
    return port_lsb(packet_bits, leaf_bits, port_bits) - addr_bits;
  endfunction
endpackage

// File: rtl/leaf_credit_counter.sv
// leaf_credit_counter: receiver-buffer credits with load, decrement and saturating refill
module leaf_credit_counter #(
  parameter int CREDIT_BITS = 8,
  parameter int MAX_CREDITS = 128,
  parameter int UPDATE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dec,
  input  logic                   inc,
  output logic [CREDIT_BITS-1:0] credits
);
  logic [31:0] sum;
  logic [31:0] nxt;
  // a send and a refill in the same cycle combine before saturation
  always_comb begin
    sum = 32'(credits) - 32'(dec) + (inc ? 32'(UPDATE_SIZE) : 32'd0);
    nxt = (sum > 32'(MAX_CREDITS)) ? 32'(MAX_CREDITS) : sum;
  end
  // a new session reloads a full buffer's worth of credits
  always_ff @(posedge clk) begin
    if (reset) credits <= '0;
    else if (load) credits <= CREDIT_BITS'(MAX_CREDITS);
    else credits <= CREDIT_BITS'(nxt);
  end
endmodule

// File: rtl/leaf_packet_sender.sv
// leaf_packet_sender: packs config and user data words into BFT packets with credit flow control and replay
module leaf_packet_sender
  import bft_pkg::*;
#(
  parameter int PACKET_BITS = BFT_PACKET_BITS,
  parameter int PAYLOAD_BITS = BFT_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS = BFT_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = BFT_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = BFT_NUM_ADDR_BITS,
  parameter int NUM_BRAM_ADDR_BITS = BFT_NUM_BRAM_ADDR_BITS,
  parameter int FREESPACE_UPDATE_SIZE = BFT_FREESPACE_UPDATE_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dest_port,
  input  logic                          cfg_vld,
  input  logic [NUM_LEAF_BITS-1:0]      cfg_leaf,
  input  logic                          cfg_port,
  input  logic [PAYLOAD_BITS-1:0]       cfg_payload,
  output logic                          cfg_ack,
  input  logic                          vld_user2sender,
  input  logic [PAYLOAD_BITS-1:0]       din_user2sender,
  output logic                          ack_sender2user,
  output logic [PACKET_BITS-1:0]        dout_sender2bft,
  input  logic                          resend,
  input  logic [PACKET_BITS-1:0]        din_bft2sender,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits
);
  localparam int LEAF_LSB = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int PORT_LSB = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int ADDR_LSB = addr_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS);
  localparam int ID_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  sender_state_t state, state_nxt;
  logic ap_start_q;
  logic start_edge;
  logic upd;
  logic unused_din;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [PACKET_BITS-1:0] replay_q;
  logic [PACKET_BITS-1:0] pkt;
  assign start_edge = ap_start & ~ap_start_q;
  assign upd = (state == STREAM) & din_bft2sender[PACKET_BITS-1] & (din_bft2sender[ID_BITS-1:0] == {leaf_q, port_q});
  assign unused_din = ^din_bft2sender[PACKET_BITS-2:ID_BITS];
  // session state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // a start edge opens (or reopens) a streaming session; only reset closes it
  always_comb state_nxt = start_edge ? STREAM : state;
  // handshakes: a replay cycle accepts nothing, config outranks data, data needs credits
  always_comb begin
    cfg_ack = ~reset & cfg_vld & ~resend;
    ack_sender2user = ~reset & (state == STREAM) & vld_user2sender & ~resend & ~cfg_vld & ~start_edge & (credits != '0);
  end
  // assemble the packet for whichever word is accepted this cycle
  always_comb begin
    pkt = '0;
    pkt[PACKET_BITS-1] = 1'b1;
    pkt[LEAF_LSB +: NUM_LEAF_BITS] = cfg_ack ? cfg_leaf : leaf_q;
    pkt[PORT_LSB +: NUM_PORT_BITS] = cfg_ack ? NUM_PORT_BITS'(cfg_port) : port_q;
    pkt[ADDR_LSB +: NUM_ADDR_BITS] = cfg_ack ? '0 : addr_q;
    pkt[PAYLOAD_BITS-1:0] = cfg_ack ? cfg_payload : din_user2sender;
  end
  // output and replay registers plus session destination and address
  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start_q <= 1'b0;
      leaf_q <= '0;
      port_q <= '0;
      addr_q <= '0;
      dout_sender2bft <= '0;
      replay_q <= '0;
    end else begin
      ap_start_q <= ap_start;
      replay_q <= resend ? replay_q : dout_sender2bft;
      dout_sender2bft <= resend ? replay_q : (cfg_ack | ack_sender2user) ? pkt : '0;
      if (start_edge) begin
        leaf_q <= dest_leaf;
        port_q <= dest_port;
        addr_q <= '0;
      end else if (ack_sender2user) addr_q <= addr_q + 1'b1;
    end
  end
  leaf_credit_counter #(
    .CREDIT_BITS(NUM_BRAM_ADDR_BITS + 1),
    .MAX_CREDITS(2 ** NUM_BRAM_ADDR_BITS),
    .UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
  ) u_credits (
    .clk(clk),
    .reset(reset),
    .load(start_edge),
    .dec(ack_sender2user),
    .inc(upd),
    .credits(credits)
  );
endmodule

// File: tb/tb_leaf_packet_sender.sv
// tb_leaf_packet_sender: directed scenarios plus random traffic against a cycle-level reference model
module tb_leaf_packet_sender;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ap_start = 1'b0;
  logic [2:0] dest_leaf = '0;
  logic [3:0] dest_port = '0;
  logic cfg_vld = 1'b0;
  logic [2:0] cfg_leaf = '0;
  logic cfg_port = 1'b0;
  logic [31:0] cfg_payload = '0;
  logic cfg_ack;
  logic vld = 1'b0;
  logic [31:0] din = '0;
  logic ack;
  logic [48:0] dout;
  logic resend = 1'b0;
  logic [48:0] din_bft = '0;
  logic [7:0] credits;
  int n_chk = 0;
  int n_pass = 0;
  bit m_stream = 0;
  bit m_apq = 0;
  int m_credits = 0;
  int m_addr = 0;
  int m_leaf = 0;
  int m_port = 0;
  logic [48:0] m_dout = '0;
  logic [48:0] m_replay = '0;

  leaf_packet_sender dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .dest_leaf(dest_leaf), .dest_port(dest_port),
    .cfg_vld(cfg_vld), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port), .cfg_payload(cfg_payload), .cfg_ack(cfg_ack),
    .vld_user2sender(vld), .din_user2sender(din), .ack_sender2user(ack), .dout_sender2bft(dout),
    .resend(resend), .din_bft2sender(din_bft), .credits(credits)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [48:0] mk(int leaf, int port, int addr, logic [31:0] pl);
    logic [63:0] v;
    v = (64'd1 << 48) | (64'(leaf) << 45) | (64'(port) << 41) | (64'(addr) << 34) | 64'(pl);
    return v[48:0];
  endfunction

  function automatic logic [48:0] upd_pkt(int leaf, int port);
    return (49'd1 << 48) | 49'(leaf * 16 + port);
  endfunction

  task automatic cycle();
    bit st, upd, ea, ec;
    int nc;
    logic [48:0] nd;
    @(negedge clk);
    st = !reset && ap_start && !m_apq;
    upd = m_stream && din_bft[48] && (din_bft[6:0] == 7'(m_leaf * 16 + m_port));
    ec = !reset && cfg_vld && !resend;
    ea = !reset && m_stream && vld && !resend && !cfg_vld && !st && m_credits > 0;
    check("dout", 64'(dout), 64'(m_dout));
    check("credits", 64'(credits), 64'(m_credits));
    check("cfg_ack", 64'(cfg_ack), 64'(ec));
    check("ack", 64'(ack), 64'(ea));
    if (reset) begin
      m_stream = 0; m_apq = 0; m_credits = 0; m_addr = 0; m_leaf = 0; m_port = 0;
      m_dout = '0; m_replay = '0;
    end else begin
      nd = resend ? m_replay : ec ? mk(cfg_leaf, cfg_port, 0, cfg_payload) : ea ? mk(m_leaf, m_port, m_addr, din) : '0;
      m_replay = resend ? m_replay : m_dout;
      m_dout = nd;
      nc = m_credits - int'(ea) + (upd ? 64 : 0);
      m_credits = st ? 128 : (nc > 128 ? 128 : nc);
      m_addr = st ? 0 : ea ? (m_addr + 1) % 128 : m_addr;
      if (st) begin m_leaf = dest_leaf; m_port = dest_port; end
      m_stream = m_stream || st;
      m_apq = ap_start;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int c0;
    @(posedge clk);
    #1;
    cycles(3);
    reset = 0;
    cycle();
    ap_start = 1; dest_leaf = 3; dest_port = 2;
    cycles(2);
    check("credits_loaded", 64'(credits), 64'd128);
    for (int i = 0; i < 5; i++) begin vld = 1; din = 32'hA0 + i; cycle(); end
    vld = 0;
    cycles(2);
    check("credits_after5", 64'(credits), 64'd123);
    vld = 1;
    for (int i = 0; i < 130; i++) begin din = $urandom; cycle(); end
    check("credits_empty", 64'(credits), 64'd0);
    din_bft = upd_pkt(3, 2);
    cycle();
    din_bft = '0;
    check("credits_refill", 64'(credits), 64'd64);
    cycles(3);
    c0 = int'(credits);
    din_bft = upd_pkt(3, 2);
    cycle();
    din_bft = '0;
    check("credits_send_upd", 64'(credits), 64'((c0 - 1 + 64) > 128 ? 128 : c0 - 1 + 64));
    din_bft = upd_pkt(5, 1);
    cycle();
    din_bft = '0;
    vld = 0;
    cycles(2);
    vld = 1; din = 32'h77; cycle();
    vld = 0; cycle();
    resend = 1; cycles(3);
    resend = 0;
    vld = 1; din = 32'h88; cycle();
    vld = 0; cycles(2);
    cfg_vld = 1; cfg_leaf = 6; cfg_port = 1; cfg_payload = 32'hC0FFEE; vld = 1; din = 32'h99;
    cycle();
    cfg_vld = 0;
    cycle();
    vld = 0; cycles(2);
    for (int i = 0; i < 1500; i++) begin
      vld = ($urandom_range(0, 9) < 7);
      din = $urandom;
      cfg_vld = ($urandom_range(0, 9) == 0);
      cfg_leaf = 3'($urandom); cfg_port = 1'($urandom); cfg_payload = $urandom;
      resend = ($urandom_range(0, 9) == 0);
      din_bft = ($urandom_range(0, 99) < 8) ? (($urandom_range(0, 1) == 0) ? upd_pkt(m_leaf, m_port) : (49'd1 << 48) | 49'($urandom)) : 49'($urandom) & ~(49'd1 << 48);
      if ($urandom_range(0, 99) == 0) begin
        ap_start = ~ap_start; dest_leaf = 3'($urandom); dest_port = 4'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0; resend = 0; cfg_vld = 0; din_bft = '0; ap_start = 0;
    cycle();
    ap_start = 1; dest_leaf = 1; dest_port = 7;
    cycles(2);
    vld = 1; din = 32'h55;
    cycle();
    reset = 1;
    cycle();
    reset = 0; ap_start = 0;
    cycles(4);
    check("credits_post_reset", 64'(credits), 64'd0);
    ap_start = 1;
    cycles(4);
    vld = 0;
    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
